// File: rtl/ex_alu_mul_if.sv
// EX-stage ALU/multiplier bundle: operation, operands and results.
// master drives valid_i/ALUCtrl_i/data1_i/data2_i; slave returns data_o/zero_o/stall_o/done_o.
interface ex_alu_mul_if #(
   parameter int WIDTH = 32
);
   logic             valid_i;
   logic [2:0]       ALUCtrl_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic [WIDTH-1:0] data_o;
   logic             zero_o;
   logic             stall_o;
   logic             done_o;

   modport master (
      output valid_i, ALUCtrl_i, data1_i, data2_i,
      input  data_o, zero_o, stall_o, done_o
   );

   modport slave (
      input  valid_i, ALUCtrl_i, data1_i, data2_i,
      output data_o, zero_o, stall_o, done_o
   );
endinterface

// File: rtl/ex_alu_mul.sv
// EX-stage ALU: 1-cycle ADD/SUB/AND/OR, WIDTH-cycle shift-add MUL with stall.
// Ports: clk_i, rst_i (async active-low), bus (ex_alu_mul_if.slave).
module ex_alu_mul #(
   parameter int WIDTH = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   ex_alu_mul_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0] res;
   logic             stall;
   logic             done;
   logic             mul_issue;

   assign mul_issue = bus.valid_i && (bus.ALUCtrl_i == OP_MUL);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      res      = '0;
      stall    = 1'b0;
      done     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (mul_issue) begin
               stall    = 1'b1;
               mcand_d  = bus.data1_i;
               mplier_d = bus.data2_i;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_MUL;
            end else begin
               case (bus.ALUCtrl_i)
                  OP_ADD:  res = bus.data1_i + bus.data2_i;
                  OP_SUB:  res = bus.data1_i - bus.data2_i;
                  OP_AND:  res = bus.data1_i & bus.data2_i;
                  OP_OR:   res = bus.data1_i | bus.data2_i;
                  default: res = '0;
               endcase
            end
         end
         S_MUL: begin
            stall = 1'b1;
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            res     = acc_q;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are forced quiet while reset is held, even though the
      // IDLE path is otherwise combinational from the inputs.
      if (!rst_i) begin
         res   = '0;
         stall = 1'b0;
         done  = 1'b0;
      end
   end

   assign bus.data_o  = res;
   assign bus.zero_o  = ~|res;
   assign bus.stall_o = stall;
   assign bus.done_o  = done;

endmodule

// File: tb/tb_ex_alu_mul.sv
// Self-checking bench for ex_alu_mul: directed plan plus random ops.
// Expected values come from a plain-arithmetic reference model.
module tb_ex_alu_mul;

   localparam int W = 32;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   ex_alu_mul_if #(.WIDTH(W)) bus ();

   ex_alu_mul #(.WIDTH(W)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_alu(input logic [2:0] c,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      case (c)
         OP_ADD:  return W'(a + b);
         OP_SUB:  return W'(a - b);
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_MUL:  return p[W-1:0];
         default: return '0;
      endcase
   endfunction

   task automatic drive(input logic v, input logic [2:0] c,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      bus.valid_i   = v;
      bus.ALUCtrl_i = c;
      bus.data1_i   = a;
      bus.data2_i   = b;
   endtask

   task automatic do_op(input string tag, input logic v,
                        input logic [2:0] c,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] e;
      @(posedge clk);
      #1;
      drive(v, c, a, b);
      e = ref_alu(c, a, b);
      @(negedge clk);
      chk({tag, "_data"}, 64'(bus.data_o), 64'(e));
      chk({tag, "_zero"}, 64'(bus.zero_o), 64'(e == '0));
      chk({tag, "_stall"}, 64'(bus.stall_o), 64'd0);
      chk({tag, "_done"}, 64'(bus.done_o), 64'd0);
   endtask

   // Issue a MUL this cycle, watch it to completion, then confirm return
   // to idle. perturb scrambles the inputs in cycle 5 of the operation.
   task automatic run_mul(input string tag,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit perturb);
      int stalls;
      int cyc;
      int busy_bad;
      bit seen;
      logic [W-1:0] e;
      e = ref_alu(OP_MUL, a, b);
      stalls   = 0;
      busy_bad = 0;
      seen     = 1'b0;
      cyc      = 0;
      @(posedge clk);
      #1;
      drive(1'b1, OP_MUL, a, b);
      rst_n = 1'b1;
      @(negedge clk);
      if (bus.stall_o) stalls++;
      if (bus.data_o !== '0 || bus.done_o !== 1'b0) busy_bad++;
      for (int k = 1; k <= 3 * W; k++) begin
         @(posedge clk);
         #1;
         cyc = k;
         if (perturb && k == 5) begin
            drive(1'($urandom), 3'($urandom), W'($urandom), W'($urandom));
         end
         @(negedge clk);
         if (bus.done_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.stall_o) stalls++;
         if (bus.data_o !== '0) busy_bad++;
      end
      chk({tag, "_seen_done"}, 64'(seen), 64'd1);
      chk({tag, "_done_cycle"}, 64'(cyc), 64'(W + 1));
      chk({tag, "_stall_cycles"}, 64'(stalls), 64'(W + 1));
      chk({tag, "_busy_outputs"}, 64'(busy_bad), 64'd0);
      chk({tag, "_product"}, 64'(bus.data_o), 64'(e));
      chk({tag, "_zero"}, 64'(bus.zero_o), 64'(e == '0));
      chk({tag, "_done_stall"}, 64'(bus.stall_o), 64'd0);
      @(posedge clk);
      #1;
      drive(1'b0, OP_ADD, '0, '0);
      @(negedge clk);
      chk({tag, "_idle_stall"}, 64'(bus.stall_o), 64'd0);
      chk({tag, "_idle_done"}, 64'(bus.done_o), 64'd0);
   endtask

   initial begin
      logic [2:0]   c;
      logic         v;
      logic [W-1:0] a;
      logic [W-1:0] b;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive(1'b1, OP_MUL, W'(5), W'(3));
      repeat (2) @(negedge clk);
      chk("rst_data", 64'(bus.data_o), 64'd0);
      chk("rst_zero", 64'(bus.zero_o), 64'd1);
      chk("rst_stall", 64'(bus.stall_o), 64'd0);
      chk("rst_done", 64'(bus.done_o), 64'd0);
      @(posedge clk);
      #1;
      drive(1'b0, OP_ADD, '0, '0);
      rst_n = 1'b1;

      do_op("add", 1'b1, OP_ADD, W'(5), W'(7));
      do_op("sub_wrap", 1'b1, OP_SUB, W'(3), W'(5));
      do_op("sub_zero", 1'b1, OP_SUB, W'(9), W'(9));
      run_mul("mul_6x7", W'(6), W'(7), 1'b0);
      run_mul("mul_wrap", '1, '1, 1'b1);

      // Abort a MUL with reset in its tenth cycle, then re-issue.
      @(posedge clk);
      #1;
      drive(1'b1, OP_MUL, W'(3), W'(4));
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_stall", 64'(bus.stall_o), 64'd0);
      chk("abort_done", 64'(bus.done_o), 64'd0);
      chk("abort_data", 64'(bus.data_o), 64'd0);
      chk("abort_zero", 64'(bus.zero_o), 64'd1);
      run_mul("mul_after_rst", W'(3), W'(4), 1'b0);

      do_op("invalid", 1'b1, 3'b111, W'(1), W'(1));
      do_op("and", 1'b1, OP_AND, W'(32'hF0F0), W'(32'hFF00));
      do_op("or", 1'b1, OP_OR, W'(32'hF0F0), W'(32'hFF00));
      run_mul("mul_zero", W'(32'h1234), '0, 1'b0);
      run_mul("mul_b2b_a", W'(11), W'(13), 1'b0);

      for (int i = 0; i < 40; i++) begin
         c = 3'($urandom);
         v = 1'($urandom);
         a = W'($urandom);
         b = W'($urandom);
         if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 15));
         if (c == OP_MUL) begin
            if ($urandom_range(0, 2) == 0) begin
               run_mul("rnd_mul", a, b, 1'($urandom));
            end else begin
               do_op("rnd_alu", 1'b1, OP_ADD, a, b);
            end
         end else begin
            do_op("rnd_alu", v, c, a, b);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_alu_mul.md
# ex_alu_mul

Execute-stage arithmetic unit for the pipelined CPU. It consumes the 3-bit ALU control code produced by the ALU control decoder together with the two operands from the ID/EX register. ADD, SUB, AND and OR complete in one cycle. MUL runs as a radix-2 shift-add multiplier over several cycles, and the unit asserts a stall request to the hazard logic so the pipeline freezes until the product is ready.

## Interface
- WIDTH, 32, operand and result width in bits (≥4)
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  reset, asynchronous, active-low
- valid_i  input  1  an instruction occupies EX this cycle
- ALUCtrl_i  input  3  operation code: 010 ADD, 110 SUB, 000 AND, 001 OR, 011 MUL; any other value is invalid
- data1_i  input  WIDTH  operand A (rs)
- data2_i  input  WIDTH  operand B (rt or immediate)
- data_o  output  WIDTH  result
- zero_o  output  1  high when data_o == 0
- stall_o  output  1  freeze request to PC, IF/ID and ID/EX
- done_o  output  1  one-cycle pulse when a MUL product is on data_o

## Operation
- FSM states: IDLE, MUL, DONE. Reset state is IDLE.
- Internal registers: acc (WIDTH), mcand (WIDTH), mplier (WIDTH), cnt (ceil(log2(WIDTH))+1 bits). All are cleared on reset.
- IDLE, non-MUL code or valid_i=0:
  - data_o is combinational from the operands: ADD = A+B and SUB = A−B, both truncated to WIDTH bits and wrapping. AND and OR are bitwise.
  - An invalid code gives data_o = 0.
  - stall_o=0, done_o=0. No state change.
- IDLE, valid_i=1 and code 011:
  - stall_o=1 combinationally in the same cycle. data_o=0.
  - At the clock edge: mcand←A, mplier←B, acc←0, cnt←0, state→MUL.
- MUL, each cycle:
  - stall_o=1, data_o=0, done_o=0.
  - At the edge: if mplier[0], then acc←acc+mcand (mod 2^WIDTH). Then mcand←mcand<<1, mplier←mplier>>1, cnt←cnt+1.
  - When cnt==WIDTH−1 at the edge, state→DONE.
- DONE (one cycle only):
  - data_o=acc, which is the low WIDTH bits of the unsigned product. This equals the low half of the signed product.
  - stall_o=0, done_o=1. The pipeline advances on this edge.
  - state→IDLE.
- While in MUL or DONE, valid_i, ALUCtrl_i and the operands are ignored; the operands were latched at issue.
- zero_o is always the reduction-NOR of data_o.
- The high half of the product is discarded. There is no overflow flag.

## Timing
- Single-cycle ops: result is valid combinationally in the issue cycle. Latency 0, no stall.
- MUL issued in cycle T:
  - stall_o is high in cycles T … T+WIDTH, which is WIDTH+1 cycles.
  - DONE, the product on data_o and done_o=1 all occur in cycle T+WIDTH+1.
  - The latency is fixed; there is no early termination on a zero multiplier.
- Back-to-back MUL: the second MUL is seen in IDLE in cycle T+WIDTH+2 and issues with no bubble beyond its own stall.
- While rst_i=0: state is IDLE, stall_o=0, done_o=0, data_o=0 and zero_o=1, regardless of the inputs.
- Reset mid-MUL aborts the operation immediately. After rst_i returns high, a MUL still presented on the inputs re-issues from scratch.
- The stall is combinational on valid_i/ALUCtrl_i only in IDLE. In MUL and DONE it is purely state-derived.

## Test plan
- ADD: A=5, B=7 → data_o=12, zero_o=0, stall_o=0, no state change.
- SUB wrap: A=3, B=5 → data_o=0xFFFFFFFE. Then A=B=9 → data_o=0, zero_o=1.
- MUL: A=6, B=7, valid_i=1 at cycle 0 → stall_o high for cycles 0–32, data_o=42 with done_o=1 at cycle 33, IDLE at cycle 34.
- MUL wrap and operand-change immunity: A=B=0xFFFFFFFF, with the inputs changed to random values in cycle 5 → data_o=0x00000001 at cycle 33.
- Reset mid-MUL: drive rst_i low at cycle 10 → stall_o, done_o and data_o drop to 0 immediately. Release rst_i with MUL 3×4 still presented → stall for 33 cycles, then data_o=12.
- Invalid code 111 with A=1, B=1 → data_o=0, zero_o=1, stall_o=0. Then AND 0xF0F0 with 0xFF00 → 0xF000, and OR of the same operands → 0xFFF0.
